// File: rtl/id_stage_pipe_if.sv
// Bundles the fs-side, register-file, es-side and ws-side signals of the decode stage.
// The master modport belongs to the surrounding pipeline; the slave modport belongs to the decode stage.
interface id_stage_pipe_if #(
  parameter int DATA_W   = 8,
  parameter int REG_AW   = 2,
  parameter int OPC_W    = 4,
  parameter int NUM_OPS  = 4,
  parameter int IMM_W    = 8,
  parameter int STALL_CW = 16
);
  localparam int INST_W = IMM_W + OPC_W + 2*REG_AW;
  localparam int BUS_W  = NUM_OPS + 2*DATA_W + IMM_W;

  logic                fs_to_ds_valid;
  logic [INST_W-1:0]   fs_to_ds_bus;
  logic                ds_allowin;
  logic                flush;
  logic [REG_AW-1:0]   rx;
  logic [REG_AW-1:0]   ry;
  logic [DATA_W-1:0]   rx_value;
  logic [DATA_W-1:0]   ry_value;
  logic                es_valid;
  logic                es_we;
  logic [REG_AW-1:0]   es_waddr;
  logic                ws_we;
  logic [REG_AW-1:0]   ws_waddr;
  logic [DATA_W-1:0]   ws_wdata;
  logic                es_allowin;
  logic                ds_to_es_valid;
  logic [BUS_W-1:0]    ds_to_es_bus;
  logic                ds_illegal;
  logic [STALL_CW-1:0] stall_cnt;

  modport master (
    output fs_to_ds_valid, fs_to_ds_bus, flush, rx_value, ry_value,
           es_valid, es_we, es_waddr, ws_we, ws_waddr, ws_wdata, es_allowin,
    input  ds_allowin, rx, ry, ds_to_es_valid, ds_to_es_bus, ds_illegal, stall_cnt
  );

  modport slave (
    input  fs_to_ds_valid, fs_to_ds_bus, flush, rx_value, ry_value,
           es_valid, es_we, es_waddr, ws_we, ws_waddr, ws_wdata, es_allowin,
    output ds_allowin, rx, ry, ds_to_es_valid, ds_to_es_bus, ds_illegal, stall_cnt
  );
endinterface

// File: rtl/id_stage_pipe.sv
// Registered instruction-decode stage: latches one instruction, decodes the opcode one-hot,
// bypasses same-cycle WB writes and stalls on RAW hazards against the instruction in es.
module id_stage_pipe #(
  parameter int DATA_W   = 8,
  parameter int REG_AW   = 2,
  parameter int OPC_W    = 4,
  parameter int NUM_OPS  = 4,
  parameter int IMM_W    = 8,
  parameter int STALL_CW = 16
) (
  input logic            clk,
  input logic            reset,
  id_stage_pipe_if.slave io
);
  localparam int INST_W = IMM_W + OPC_W + 2*REG_AW;

  logic                ds_valid;
  logic [INST_W-1:0]   inst_r;
  logic [STALL_CW-1:0] stall_r;

  logic [REG_AW-1:0]   rx_a;
  logic [REG_AW-1:0]   ry_a;
  logic [OPC_W-1:0]    opcode;
  logic [IMM_W-1:0]    imm;
  logic [NUM_OPS-1:0]  onehot;
  logic [DATA_W-1:0]   rx_val;
  logic [DATA_W-1:0]   ry_val;
  logic                ready_go;
  logic                allowin;

  function automatic logic [STALL_CW-1:0] sat_inc(input logic [STALL_CW-1:0] v);
    return (&v) ? v : v + STALL_CW'(1);
  endfunction

  // Opcode k (1..NUM_OPS) lights bit NUM_OPS-k, so op 1 lands on the MSB.
  function automatic logic [NUM_OPS-1:0] decode(input logic [OPC_W-1:0] op);
    logic [NUM_OPS-1:0] oh;
    oh = '0;
    for (int k = 1; k <= NUM_OPS; k++) begin
      if (op == OPC_W'(k)) oh[NUM_OPS-k] = 1'b1;
    end
    return oh;
  endfunction

  // Decode stage: fields, bypass and hazard, all combinational from inst_r
  assign rx_a   = inst_r[REG_AW-1:0];
  assign ry_a   = inst_r[2*REG_AW-1:REG_AW];
  assign opcode = inst_r[2*REG_AW +: OPC_W];
  assign imm    = inst_r[INST_W-1 -: IMM_W];
  assign onehot = decode(opcode);

  assign rx_val = (io.ws_we && io.ws_waddr == rx_a) ? io.ws_wdata : io.rx_value;
  assign ry_val = (io.ws_we && io.ws_waddr == ry_a) ? io.ws_wdata : io.ry_value;

  assign ready_go = !(io.es_valid && io.es_we && (io.es_waddr == rx_a || io.es_waddr == ry_a));
  assign allowin  = !ds_valid || (ready_go && io.es_allowin);

  assign io.rx             = rx_a;
  assign io.ry             = ry_a;
  assign io.ds_allowin     = allowin;
  assign io.ds_to_es_valid = ds_valid && ready_go;
  assign io.ds_to_es_bus   = ds_valid ? {onehot, ry_val, rx_val, imm} : '0;
  assign io.ds_illegal     = ds_valid && (onehot == '0);
  assign io.stall_cnt      = stall_r;

  // fs -> ds boundary: instruction latch, occupancy and stall counter
  always_ff @(posedge clk) begin
    if (reset) begin
      ds_valid <= 1'b0;
      inst_r   <= '0;
      stall_r  <= '0;
    end else begin
      if (ds_valid && !ready_go && !io.flush) stall_r <= sat_inc(stall_r);
      if (io.flush) begin
        ds_valid <= 1'b0;
      end else if (allowin) begin
        ds_valid <= io.fs_to_ds_valid;
      end
      if (io.fs_to_ds_valid && allowin && !io.flush) inst_r <= io.fs_to_ds_bus;
    end
  end
endmodule
